instr_fetch: RTL

//  Instruction fetch stage directly upstream of exe_engine; supplies its 5-bit instr input.

---
 rtl/instr_fetch_pkg.sv | 30 +++
 rtl/instr_fetch_pc_reg.sv | 36 +++
 rtl/instr_fetch.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: exe_engine opcode map,
// default widths and the fetch FSM state encoding.
package instr_fetch_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 5;

    // exe_engine opcode map; OP_HALT stops the fetch stage once consumed.
    typedef enum logic [4:0] {
        OP_NOP  = 5'h00,
        OP_ADD  = 5'h01,
        OP_SUB  = 5'h02,
        OP_AND  = 5'h03,
        OP_OR   = 5'h04,
        OP_XOR  = 5'h05,
        OP_LD   = 5'h08,
        OP_ST   = 5'h09,
        OP_JMP  = 5'h10,
        OP_BEQ  = 5'h11,
        OP_HALT = 5'h1F
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register for the fetch stage.
// Load priority: reset > load (start/jump) > increment; increment wraps modulo 2**ADDR_W.
module instr_fetch_pc_reg #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_val;
        end else if (inc_en) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding exe_engine: req/ack reads from instruction
// memory, one instruction in flight, HALT stop and jump redirects.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                 ADDR_W  = ADDR_W_DEF,
    parameter int                 INSTR_W = INSTR_W_DEF,
    parameter logic [INSTR_W-1:0] HALT_OP = INSTR_W'(OP_HALT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted,
    output logic [1:0]         state_dbg
);

    // Handshake: instr transfers on a posedge where instr_valid=1 and instr_ready=1;
    // instr stays stable while instr_valid=1; instr_valid may not depend on instr_ready.
    fetch_state_e       state_d, state_q;
    logic               req_d, req_q;
    logic [ADDR_W-1:0]  addr_d, addr_q;
    logic [INSTR_W-1:0] instr_d, instr_q;
    logic               valid_d, valid_q;
    logic               flush_d, flush_q;
    logic               pc_load;
    logic [ADDR_W-1:0]  pc_load_val;
    logic               pc_inc;

    instr_fetch_pc_reg #(.ADDR_W(ADDR_W)) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .load_en  (pc_load),
        .load_val (pc_load_val),
        .inc_en   (pc_inc),
        .pc       (pc)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        flush_d     = flush_q;
        pc_load     = 1'b0;
        pc_load_val = start_addr;
        pc_inc      = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    pc_load = 1'b1;
                    addr_d  = start_addr;
                    req_d   = 1'b1;
                    flush_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (jump_en) begin
                    pc_load     = 1'b1;
                    pc_load_val = jump_addr;
                    if (imem_ack) begin
                        addr_d  = jump_addr;
                        flush_d = 1'b0;
                    end else begin
                        // Request in flight to the old address; its data is dropped on ack.
                        flush_d = 1'b1;
                    end
                end else if (imem_ack) begin
                    if (flush_q) begin
                        flush_d = 1'b0;
                        addr_d  = pc;
                    end else begin
                        instr_d = imem_rdata;
                        pc_inc  = 1'b1;
                        req_d   = 1'b0;
                        valid_d = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (jump_en) begin
                    // A jump beats HALT even when the instruction is consumed this cycle.
                    pc_load     = 1'b1;
                    pc_load_val = jump_addr;
                    valid_d     = 1'b0;
                    req_d       = 1'b1;
                    addr_d      = jump_addr;
                    state_d     = ST_REQ;
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                    if (instr_q == HALT_OP) begin
                        state_d = ST_HALTED;
                    end else begin
                        req_d   = 1'b1;
                        addr_d  = pc;
                        state_d = ST_REQ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign busy        = (state_q == ST_REQ) || (state_q == ST_ISSUE);
    assign halted      = (state_q == ST_HALTED);
    assign state_dbg   = state_q;

endmodule
